instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Responder end of the instruction-fetch memory port: owns the instruction storage array and answers `mem_addr` / `mem_read_en` with `mem_read_val`.
- Also provides a byte-serial loader port. A boot or debug host streams a program image into the array before the core fetches from it.
- Sits between the instruction-fetch initiator and the board-level program loader (UART/JTAG bridge).

Parameters:
- MEM_WIDTH, 32, word width in bits; must be a multiple of 8, minimum 8.
- MEM_SIZE, 256, number of words; must be at least 2.
- Derived: AW = $clog2(MEM_SIZE); BPW = MEM_WIDTH/8 (bytes per word).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_addr  input  AW  fetch word address from the initiator.
- mem_read_en  input  1  fetch request, sampled every cycle.
- mem_read_val  output  MEM_WIDTH  registered fetch data.
- load_start  input  1  single-cycle pulse; begins (or restarts) a full-image load.
- load_valid  input  1  load_byte is valid this cycle.
- load_byte  input  8  image byte, little-endian within each word.
- load_ready  output  1  loader accepts a byte this cycle; a byte transfers only when load_valid and load_ready are both 1.
- load_done  output  1  one-cycle pulse after the final word is written.
- busy  output  1  high while in LOAD.

Behaviour:
- Reset is synchronous and active-high on clk.
- Reset values: state=IDLE, mem_read_val=0, load_ready=0, load_done=0, busy=0; byte counter, word address and shift register = 0.
- Array contents are NOT cleared by reset. Reset mid-load abandons the load; words already written remain.

State machine:
- IDLE:
  - load_start → LOAD; clear the byte counter, word address (waddr) and shift register.
- LOAD:
  - load_ready=1, busy=1.
  - Each accepted byte: if the byte counter < BPW-1, shift the byte into the assembly register at byte lane [counter] and increment the counter.
  - If the byte counter == BPW-1: write {load_byte, assembled lower bytes} to mem[waddr] on that edge; counter ← 0.
  - After that write: if waddr == MEM_SIZE-1 → IDLE and pulse load_done next cycle; else waddr+1.
  - load_start while in LOAD restarts: counters and shift register are cleared, and any byte offered in that same cycle is discarded.
  - No timeout; gaps between bytes of any length are legal.

Fetch path:
- Outside LOAD, if mem_read_en=1 at an edge, mem_read_val ← mem[mem_addr]. Latency is exactly 1 cycle.
- If mem_read_en=0, mem_read_val holds its last value.
- In LOAD, mem_read_val ← 0 every cycle and reads are ignored.
- On the cycle LOAD→IDLE, the final write lands on that edge. A fetch issued in the following cycle returns the new data.

Boundary and simultaneous cases:
- In IDLE, load_start and load_valid together in the same cycle: start is taken and the byte is ignored, because load_ready=0 in IDLE.
- mem_addr values ≥ MEM_SIZE (only possible for non-power-of-2 sizes) return 0.
- waddr never wraps. The load always ends exactly after MEM_SIZE×BPW accepted bytes.

Optional Feature:
Macro `INSTR_MEM_LOAD_CHECKSUM_EN`:
- Defined:
  - Adds output port load_checksum [MEM_WIDTH-1:0], reset to 0.
  - Cleared on every load_start.
  - On each word write, load_checksum ← load_checksum XOR written word.
  - Holds its value after load_done until the next load_start or reset.
- Undefined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
1. MEM_SIZE=4, MEM_WIDTH=32. Reset, then load_start, then stream 16 bytes 0x00..0x0F with load_valid constantly high → load_done pulses exactly once, 1 cycle after the 16th byte. Then fetch addr 0,1,2,3 back-to-back → mem_read_val = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, each 1 cycle after its request.
2. Same load with load_valid toggling 1/0 every cycle → identical array contents. busy stays high throughout the load. load_ready=0 in IDLE both before and after the load.
3. Assert reset after 6 bytes, then fetch addr 0 → 0x03020100 (word 0 was written before reset). mem_read_val=0 immediately after reset. busy=0.
4. Pulse load_start after 5 bytes, then stream 16 bytes 0xA0..0xAF → word 0 = 0xA3A2A1A0. The earlier partial word is never written.
5. In LOAD, hold mem_read_en=1 with addr 1 → mem_read_val=0 throughout. In IDLE with mem_read_en=0 → mem_read_val holds its previous value for 10 cycles.
6. With `INSTR_MEM_LOAD_CHECKSUM_EN` defined, run the scenario 1 load → load_checksum = 0x03020100^0x07060504^0x0B0A0908^0x0F0E0D0C = 0x00000000. Then run the scenario 4 data (bytes 0xA0..0xAF) → 0x00000000. Then load bytes 0x01,0,0,0 followed by zeros → 0x00000001.

Source files
------------

// File: rtl/instr_mem_responder_if.sv
// Instruction memory port bundle: the fetch request/response signals plus the
// byte-serial loader handshake. The master side is the fetch initiator and the
// program loader together; the slave side is the memory responder.
// Optional macro INSTR_MEM_LOAD_CHECKSUM_EN adds the load_checksum signal.
interface instr_mem_responder_if #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256
);
  localparam int AW = $clog2(MEM_SIZE);

  logic [AW-1:0]        mem_addr;
  logic                 mem_read_en;
  logic [MEM_WIDTH-1:0] mem_read_val;
  logic                 load_start;
  logic                 load_valid;
  logic [7:0]           load_byte;
  logic                 load_ready;
  logic                 load_done;
  logic                 busy;
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
  logic [MEM_WIDTH-1:0] load_checksum;
`endif

  modport master (
    output mem_addr,
    output mem_read_en,
    output load_start,
    output load_valid,
    output load_byte,
    input  mem_read_val,
    input  load_ready,
    input  load_done,
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
    input  load_checksum,
`endif
    input  busy
  );

  modport slave (
    input  mem_addr,
    input  mem_read_en,
    input  load_start,
    input  load_valid,
    input  load_byte,
    output mem_read_val,
    output load_ready,
    output load_done,
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
    output load_checksum,
`endif
    output busy
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: owns the instruction array, answers fetches
// with one cycle of latency, and accepts a full program image over a
// byte-serial loader port (little-endian bytes within each word).
// Optional macro INSTR_MEM_LOAD_CHECKSUM_EN adds a running XOR of every word
// written during a load, exposed as load_checksum.
module instr_mem_responder #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_mem_responder_if.slave   bus
);

  localparam int AW  = $clog2(MEM_SIZE);
  localparam int AWP = AW + 1;
  localparam int BPW = MEM_WIDTH / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_nextState;

  logic [CW-1:0]        r_byteCnt;
  logic [AW-1:0]        r_waddr;
  logic [MEM_WIDTH-1:0] r_shift;
  logic [MEM_WIDTH-1:0] r_readVal;
  logic                 r_loadDone;
  logic [MEM_WIDTH-1:0] r_mem [MEM_SIZE];

  logic                 w_accept;
  logic                 w_lastByte;
  logic                 w_lastWord;
  logic                 w_wordWrite;
  logic                 w_finalWrite;
  logic                 w_addrInRange;
  logic                 w_loadReady;
  logic                 w_busy;
  logic [MEM_WIDTH-1:0] w_wordData;

  // Decode the loader handshake; a start pulse always wins over a byte in the same cycle.
  always_comb begin
    w_lastByte    = (r_byteCnt == CW'(BPW - 1));
    w_lastWord    = (r_waddr == AW'(MEM_SIZE - 1));
    w_accept      = (r_state == LOAD) && bus.load_valid && !bus.load_start;
    w_wordWrite   = w_accept && w_lastByte;
    w_finalWrite  = w_wordWrite && w_lastWord;
    w_wordData    = r_shift;
    w_wordData[MEM_WIDTH-1 -: 8] = bus.load_byte;
    w_addrInRange = ({1'b0, bus.mem_addr} < AWP'(MEM_SIZE));
  end

  // State register for the load FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and Moore outputs: ready/busy are asserted for the whole LOAD state.
  always_comb begin
    w_nextState = r_state;
    w_loadReady = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.load_start) begin
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        w_loadReady = 1'b1;
        w_busy      = 1'b1;
        if (bus.load_start) begin
          w_nextState = LOAD;
        end else if (w_finalWrite) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Byte assembly, word address advance and the registered done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byteCnt  <= '0;
      r_waddr    <= '0;
      r_shift    <= '0;
      r_loadDone <= 1'b0;
    end else begin
      r_loadDone <= w_finalWrite;
      if (bus.load_start) begin
        r_byteCnt <= '0;
        r_waddr   <= '0;
        r_shift   <= '0;
      end else if (w_accept) begin
        if (w_lastByte) begin
          r_byteCnt <= '0;
          if (!w_lastWord) begin
            r_waddr <= r_waddr + AW'(1);
          end
        end else begin
          r_shift[{r_byteCnt, 3'b000} +: 8] <= bus.load_byte;
          r_byteCnt <= r_byteCnt + CW'(1);
        end
      end
    end
  end

  // Array write port; contents deliberately survive reset so a reset mid-load keeps finished words.
  always_ff @(posedge clk) begin
    if (w_wordWrite && !reset) begin
      r_mem[r_waddr] <= w_wordData;
    end
  end

  // Fetch port: one-cycle read outside LOAD, forced to zero while a load is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readVal <= '0;
    end else if (r_state == LOAD) begin
      r_readVal <= '0;
    end else if (bus.mem_read_en) begin
      r_readVal <= w_addrInRange ? r_mem[bus.mem_addr] : '0;
    end
  end

  assign bus.mem_read_val = r_readVal;
  assign bus.load_ready   = w_loadReady;
  assign bus.busy         = w_busy;
  assign bus.load_done    = r_loadDone;

`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
  logic [MEM_WIDTH-1:0] r_checksum;

  // Running XOR of every word written during the current load; cleared by each start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (bus.load_start) begin
      r_checksum <= '0;
    end else if (w_wordWrite) begin
      r_checksum <= r_checksum ^ w_wordData;
    end
  end

  assign bus.load_checksum = r_checksum;
`else
  // Without the checksum option the load path only fills the array.
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder with a 4-word, 32-bit array.
// Fetch results go through a scoreboard queue; load behaviour is tracked by a
// small byte-stream model of the image being written.
module tb_instr_mem_responder;

  localparam int MEM_WIDTH = 32;
  localparam int MEM_SIZE  = 4;
  localparam int BPW       = MEM_WIDTH / 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [MEM_WIDTH-1:0] expQ[$];
  logic [MEM_WIDTH-1:0] modelMem [MEM_SIZE];
  int                   modelCnt;
  int                   modelWaddr;
  logic [MEM_WIDTH-1:0] modelShift;
  logic [MEM_WIDTH-1:0] modelCsum;
  bit                   modelLoading = 1'b0;

  int donePulses;
  bit doneOnLast;
  int busyLow;
  int readNonZero;

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  instr_mem_responder_if #(.MEM_WIDTH(MEM_WIDTH), .MEM_SIZE(MEM_SIZE)) bus ();

  instr_mem_responder #(.MEM_WIDTH(MEM_WIDTH), .MEM_SIZE(MEM_SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelStart();
    modelCnt     = 0;
    modelWaddr   = 0;
    modelShift   = '0;
    modelCsum    = '0;
    modelLoading = 1'b1;
  endtask

  task automatic modelAccept(input logic [7:0] b, output bit finalWord);
    logic [MEM_WIDTH-1:0] w;
    finalWord = 1'b0;
    if (!modelLoading) return;
    if (modelCnt < BPW - 1) begin
      modelShift[modelCnt*8 +: 8] = b;
      modelCnt++;
    end else begin
      w = modelShift;
      w[MEM_WIDTH-1 -: 8] = b;
      modelMem[modelWaddr] = w;
      modelCsum ^= w;
      modelCnt = 0;
      if (modelWaddr == MEM_SIZE - 1) begin
        modelLoading = 1'b0;
        finalWord    = 1'b1;
      end else begin
        modelWaddr++;
      end
    end
  endtask

  task automatic startLoad(input bit withByte, input logic [7:0] b);
    bus.load_start = 1'b1;
    bus.load_valid = withByte;
    bus.load_byte  = b;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    modelStart();
  endtask

  task automatic clearStats();
    donePulses  = 0;
    doneOnLast  = 1'b0;
    busyLow     = 0;
    readNonZero = 0;
  endtask

  task automatic sampleCycle(input bit finalWord);
    if (bus.load_done === 1'b1) begin
      donePulses++;
      if (finalWord) doneOnLast = 1'b1;
    end
    if (bus.mem_read_val !== '0) readNonZero++;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit fin;
    if (bus.busy !== 1'b1) busyLow++;
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    tick();
    bus.load_valid = 1'b0;
    modelAccept(b, fin);
    sampleCycle(fin);
  endtask

  task automatic idleGap();
    if (bus.busy !== 1'b1) busyLow++;
    tick();
    sampleCycle(1'b0);
  endtask

  task automatic streamBytes(input logic [7:0] first, input int count, input bit toggle);
    for (int i = 0; i < count; i++) begin
      sendByte(first + 8'(i));
      if (toggle && i != count - 1) idleGap();
    end
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.mem_addr    = '0;
    bus.mem_read_en = 1'b0;
    bus.load_start  = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_byte   = '0;
    tick();
    tick();
    checks++;
    if (bus.mem_read_val !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_read_val: got %h expected %h", bus.mem_read_val, 32'h0);
    end
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_load_ready: got %b expected 0", bus.load_ready);
    end
    checks++;
    if (bus.load_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_load_done: got %b expected 0", bus.load_done);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
    end
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
    checks++;
    if (bus.load_checksum !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_checksum: got %h expected %h", bus.load_checksum, 32'h0);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stream_load();
    logic [31:0] words [4];
    logic [31:0] exp;
    words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    startLoad(1'b0, 8'h00);
    checks++;
    if (bus.busy !== 1'b1 || bus.load_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stream_enter_load: got busy=%b ready=%b expected busy=1 ready=1", bus.busy, bus.load_ready);
    end
    clearStats();
    streamBytes(8'h00, 16, 1'b0);
    checks++;
    if (donePulses !== 1 || doneOnLast !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stream_done_pulse: got pulses=%0d onLast=%0d expected pulses=1 onLast=1", donePulses, doneOnLast);
    end
    checks++;
    if (busyLow !== 0 || readNonZero !== 0) begin
      errors++;
      $display("[TB] FAIL stream_busy_read: got busyLow=%0d readNonZero=%0d expected 0 and 0", busyLow, readNonZero);
    end
    tick();
    checks++;
    if (bus.load_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_after_done: got done=%b busy=%b expected done=0 busy=0", bus.load_done, bus.busy);
    end
    bus.mem_read_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.mem_addr = 2'(a);
      expQ.push_back(words[a]);
      tick();
      exp = expQ.pop_front();
      checks++;
      if (bus.mem_read_val !== exp) begin
        errors++;
        $display("[TB] FAIL stream_fetch_%0d: got %h expected %h", a, bus.mem_read_val, exp);
      end
    end
    bus.mem_read_en = 1'b0;
  endtask

  task automatic test_toggle_load();
    logic [31:0] exp;
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL toggle_ready_idle_before: got %b expected 0", bus.load_ready);
    end
    startLoad(1'b0, 8'h00);
    clearStats();
    streamBytes(8'h00, 16, 1'b1);
    checks++;
    if (donePulses !== 1 || doneOnLast !== 1'b1 || busyLow !== 0) begin
      errors++;
      $display("[TB] FAIL toggle_done_busy: got pulses=%0d onLast=%0d busyLow=%0d expected 1 1 0", donePulses, doneOnLast, busyLow);
    end
    tick();
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL toggle_ready_idle_after: got %b expected 0", bus.load_ready);
    end
    bus.mem_read_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.mem_addr = 2'(a);
      expQ.push_back(modelMem[a]);
      tick();
      exp = expQ.pop_front();
      checks++;
      if (bus.mem_read_val !== exp) begin
        errors++;
        $display("[TB] FAIL toggle_fetch_%0d: got %h expected %h", a, bus.mem_read_val, exp);
      end
    end
    bus.mem_read_en = 1'b0;
  endtask

  task automatic test_restart();
    logic [31:0] exp;
    startLoad(1'b0, 8'h00);
    streamBytes(8'h50, 5, 1'b0);
    startLoad(1'b1, 8'hEE);
    clearStats();
    streamBytes(8'hA0, 16, 1'b0);
    checks++;
    if (donePulses !== 1 || doneOnLast !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_done_pulse: got pulses=%0d onLast=%0d expected 1 1", donePulses, doneOnLast);
    end
    tick();
    bus.mem_read_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.mem_addr = 2'(a);
      expQ.push_back(a == 0 ? 32'hA3A2A1A0 : modelMem[a]);
      tick();
      exp = expQ.pop_front();
      checks++;
      if (bus.mem_read_val !== exp) begin
        errors++;
        $display("[TB] FAIL restart_fetch_%0d: got %h expected %h", a, bus.mem_read_val, exp);
      end
    end
    bus.mem_read_en = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] exp;
    startLoad(1'b0, 8'h00);
    streamBytes(8'h00, 6, 1'b0);
    reset = 1'b1;
    tick();
    modelLoading = 1'b0;
    checks++;
    if (bus.mem_read_val !== 32'h0 || bus.busy !== 1'b0 || bus.load_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got val=%h busy=%b ready=%b expected 0 0 0", bus.mem_read_val, bus.busy, bus.load_ready);
    end
    reset = 1'b0;
    tick();
    bus.mem_read_en = 1'b1;
    for (int a = 0; a < 2; a++) begin
      bus.mem_addr = 2'(a);
      expQ.push_back(a == 0 ? 32'h03020100 : modelMem[1]);
      tick();
      exp = expQ.pop_front();
      checks++;
      if (bus.mem_read_val !== exp) begin
        errors++;
        $display("[TB] FAIL midreset_fetch_%0d: got %h expected %h", a, bus.mem_read_val, exp);
      end
    end
    bus.mem_read_en = 1'b0;
  endtask

  task automatic test_fetch_hold();
    logic [31:0] exp;
    logic [31:0] holdVal;
    bus.mem_read_en = 1'b1;
    bus.mem_addr    = 2'd1;
    startLoad(1'b0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.mem_read_val !== 32'h0) begin
        errors++;
        $display("[TB] FAIL load_read_zero_%0d: got %h expected %h", c, bus.mem_read_val, 32'h0);
      end
    end
    clearStats();
    streamBytes(8'h20, 16, 1'b0);
    checks++;
    if (readNonZero !== 0 || donePulses !== 1) begin
      errors++;
      $display("[TB] FAIL load_read_stream: got readNonZero=%0d pulses=%0d expected 0 1", readNonZero, donePulses);
    end
    bus.mem_addr = 2'd3;
    expQ.push_back(modelMem[3]);
    tick();
    exp = expQ.pop_front();
    checks++;
    if (bus.mem_read_val !== exp) begin
      errors++;
      $display("[TB] FAIL fetch_after_final_write: got %h expected %h", bus.mem_read_val, exp);
    end
    holdVal         = exp;
    bus.mem_read_en = 1'b0;
    bus.mem_addr    = 2'd0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (bus.mem_read_val !== holdVal) begin
        errors++;
        $display("[TB] FAIL hold_read_val_%0d: got %h expected %h", c, bus.mem_read_val, holdVal);
      end
    end
  endtask

`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    startLoad(1'b0, 8'h00);
    streamBytes(8'h00, 4, 1'b0);
    checks++;
    if (bus.load_checksum !== 32'h03020100) begin
      errors++;
      $display("[TB] FAIL checksum_first_word: got %h expected %h", bus.load_checksum, 32'h03020100);
    end
    streamBytes(8'h04, 12, 1'b0);
    checks++;
    if (bus.load_checksum !== 32'h0) begin
      errors++;
      $display("[TB] FAIL checksum_ramp: got %h expected %h", bus.load_checksum, 32'h0);
    end
    tick();
    startLoad(1'b0, 8'h00);
    streamBytes(8'hA0, 16, 1'b0);
    checks++;
    if (bus.load_checksum !== 32'h0) begin
      errors++;
      $display("[TB] FAIL checksum_a_image: got %h expected %h", bus.load_checksum, 32'h0);
    end
    tick();
    startLoad(1'b0, 8'h00);
    sendByte(8'h01);
    for (int i = 0; i < 15; i++) sendByte(8'h00);
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (bus.load_checksum !== 32'h1) begin
      errors++;
      $display("[TB] FAIL checksum_one_hold: got %h expected %h", bus.load_checksum, 32'h1);
    end
    startLoad(1'b0, 8'h00);
    checks++;
    if (bus.load_checksum !== 32'h0) begin
      errors++;
      $display("[TB] FAIL checksum_clear_on_start: got %h expected %h", bus.load_checksum, 32'h0);
    end
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_stream_load();
    test_toggle_load();
    test_restart();
    test_reset_mid_load();
    test_fetch_hold();
`ifdef INSTR_MEM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
